// File: rtl/ram_burst_ctrl.sv
// Burst read/write controller in front of a single-port RAM with a shared
// bidirectional data bus; read words leave through a registered, stallable slot.
module ram_burst_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [3:0]        beats_left_q, beats_left_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              slot_free;

  // The bus is only driven during an actual write beat; otherwise the RAM owns it.
  assign mem_rw    = (state_q == WR) && wr_valid;
  assign mem_data  = mem_rw ? wr_data : {DATA_W{1'bz}};
  assign mem_addr  = cur_addr_q;

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WR);
  assign busy      = (state_q != IDLE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign slot_free = !rd_valid_q || rd_ready;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;

    // Default slot drain; a capture below overrides it.
    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_d   = cmd_addr;
          beats_left_d = cmd_len;
          state_d      = cmd_we ? WR : RD;
        end
      end
      WR: begin
        if (wr_valid) begin
          cur_addr_d = cur_addr_q + 1'b1;
          if (beats_left_q == 4'd0) state_d = IDLE;
          else                      beats_left_d = beats_left_q - 4'd1;
        end
      end
      RD: begin
        if (slot_free) begin
          rd_data_d  = mem_data;
          rd_valid_d = 1'b1;
          rd_last_d  = (beats_left_q == 4'd0);
          cur_addr_d = cur_addr_q + 1'b1;
          if (beats_left_q == 4'd0) state_d = IDLE;
          else                      beats_left_d = beats_left_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: behavioural RAM on the bus, shadow memory and a
// read scoreboard queue checked as words are consumed.
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid, rd_ready, rd_last, busy;
  logic [11:0] mem_addr;
  logic        mem_rw;
  wire  [15:0] mem_data;

  ram_burst_ctrl #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read onto the bus, write on the strobe edge.
  logic [15:0] ram [4096];
  logic [15:0] shadow [4096];
  assign mem_data = mem_rw ? 16'bz : ram[mem_addr];
  always @(posedge clk) if (mem_rw) ram[mem_addr] <= mem_data;

  int n_cmp = 0, n_err = 0;
  logic [16:0] exp_q [$];
  int rdy_mode = 0, cyc = 0, rw_cnt = 0;
  logic hold_vld = 1'b0;
  logic [11:0] held_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rd_ready: always high, or the 1,0,0 repeating back-pressure pattern.
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      rd_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  // Output monitor: pop one expected word per consumed word.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_rw) rw_cnt++;
        if (hold_vld) chk("addr_hold", {20'd0, mem_addr}, {20'd0, held_addr});
        hold_vld  = busy && !wr_ready && rd_valid && !rd_ready;
        held_addr = mem_addr;
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) chk("rd_extra", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("rd_data", {16'd0, rd_data}, {16'd0, e[15:0]});
            chk("rd_last", {31'd0, rd_last}, {31'd0, e[16]});
          end
        end
      end else hold_vld = 1'b0;
    end
  end

  task automatic send_cmd(input logic we, input logic [11:0] a, input logic [3:0] l);
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("cmd_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wr_beat(input logic [11:0] a, input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    wr_valid = 1'b1; wr_data = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wr_timeout", 32'd0, 32'd1);
    chk("wr_addr", {20'd0, mem_addr}, {20'd0, a});
    chk("wr_strobe", {31'd0, mem_rw}, 32'd1);
    chk("wr_bus", {16'd0, mem_data}, {16'd0, d});
    shadow[a] = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wr_burst(input logic [11:0] a, input logic [3:0] l,
                          input logic [15:0] d0, input int gap);
    logic [11:0] ad;
    ad = a;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (i != 0) repeat (gap) begin @(posedge clk); #1; end
      wr_beat(ad, d0 + 16'(i));
      ad = ad + 12'd1;
    end
    @(negedge clk);
    chk("wr_done_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rd_burst(input logic [11:0] a, input logic [3:0] l);
    logic ok;
    logic [11:0] ad;
    ok = 1'b0;
    send_cmd(1'b0, a, l);
    ad = a;
    for (int i = 0; i <= int'(l); i++) begin
      exp_q.push_back({(i == int'(l)), shadow[ad]});
      ad = ad + 12'd1;
    end
    @(negedge clk);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    chk("rd_vld_early", {31'd0, rd_valid}, 32'd0);
    @(negedge clk);
    chk("rd_vld_first", {31'd0, rd_valid}, 32'd1);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !busy && !rd_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("rd_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, {30'd0, cmd_ready, wr_ready}, 32'd2);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_rw"},    {31'd0, mem_rw}, 32'd0);
    chk({tag, "_addr"},  {20'd0, mem_addr}, 32'd0);
    chk({tag, "_slot"},  {14'd0, rd_valid, rd_last, rd_data}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin ram[i] = 16'h0; shadow[i] = 16'h0; end
    #1 chk_reset_outs("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray wr_valid in IDLE must not strobe.
    wr_valid = 1'b1;
    @(negedge clk);
    chk("idle_wr_ignored", {31'd0, mem_rw}, 32'd0);
    @(posedge clk); #1 wr_valid = 1'b0;

    wr_burst(12'h123, 4'd0, 16'hA5C3, 0);
    rd_burst(12'h123, 4'd0);

    wr_burst(12'hFFE, 4'd3, 16'd1, 0);
    rd_burst(12'hFFE, 4'd3);

    wr_burst(12'h400, 4'd15, 16'h1000, 0);
    rdy_mode = 1;
    rd_burst(12'h400, 4'd15);
    rdy_mode = 0;
    @(posedge clk); #1;

    rw_cnt = 0;
    wr_burst(12'h600, 4'd2, 16'hBEEF, 2);
    chk("gap_strobes", rw_cnt, 32'd3);
    rd_burst(12'h600, 4'd2);

    // Reset in the middle of a 10-beat write, after beat 5.
    send_cmd(1'b1, 12'h200, 4'd9);
    for (int i = 0; i < 5; i++) wr_beat(12'h200 + 12'(i), 16'h5000 + 16'(i));
    wr_valid = 1'b1; wr_data = 16'hDEAD;
    rst_n = 1'b0;
    #1 chk_reset_outs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    rd_burst(12'h200, 4'd4);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
